// File: rtl/rps_match.sv
// ---------------------------------------------------------------------------
// rps_match
//
// Purpose:
//   Referee for a two-player rock-paper-scissors match, with an optional
//   lizard-spock extension. A rising edge on start captures both moves and
//   the mode. One cycle later the round is scored and a one-cycle
//   round_valid pulse reports the result. The match ends when a player
//   reaches WIN_TARGET round wins or when MAX_ROUNDS scored rounds have
//   been played.
//
// Ports:
//   clk          - single clock, rising-edge active
//   rst          - asynchronous active-high reset
//   start        - level input; only a rising edge requests a round
//   clear_match  - synchronous match restart (priority over start)
//   mode         - 0 classic (3 moves), 1 extended (5 moves)
//   p1_move      - player-1 move: 0 rock, 1 paper, 2 scissors,
//                  3 lizard, 4 spock
//   p2_move      - player-2 move, same encoding
//   round_valid  - one-cycle pulse, round_result is valid while high
//   round_result - 00 tie, 01 P1 wins, 10 P2 wins, 11 invalid move
//   p1_score     - player-1 round wins
//   p2_score     - player-2 round wins
//   round_count  - scored rounds (ties included, invalid rounds excluded)
//   match_over   - high while the match is finished
//   match_winner - 00 none, 01 P1, 10 P2, 11 draw
// ---------------------------------------------------------------------------
module rps_match #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 4,
  parameter int MAX_ROUNDS = 7,
  parameter int ROUND_W    = $clog2(MAX_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear_match,
  input  logic               mode,
  input  logic [2:0]         p1_move,
  input  logic [2:0]         p2_move,
  output logic               round_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [ROUND_W-1:0] round_count,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [ROUND_W-1:0] LIMIT  = ROUND_W'(MAX_ROUNDS);

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [1:0] RES_BAD = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic       start_q;
  logic       start_armed;
  logic       mode_q;
  logic [2:0] p1_q;
  logic [2:0] p2_q;

  logic               start_edge;
  logic               eval_bad;
  logic [1:0]         eval_result;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;
  logic [ROUND_W-1:0] count_next;
  logic               match_end;
  logic [1:0]         winner_next;

  // A move is legal only inside the move set of the captured mode.
  function automatic logic move_invalid(input logic ext, input logic [2:0] m);
    return ext ? (m >= 3'd5) : (m >= 3'd3);
  endfunction

  // Bit b of the mask is set when move a defeats move b. Classic mode only
  // ever reaches moves 0..2, where this table reduces to plain RPS.
  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    logic [4:0] mask;
    logic [4:0] shifted;
    case (a)
      3'd0:    mask = 5'b01100;  // rock: scissors, lizard
      3'd1:    mask = 5'b10001;  // paper: rock, spock
      3'd2:    mask = 5'b01010;  // scissors: paper, lizard
      3'd3:    mask = 5'b10010;  // lizard: paper, spock
      3'd4:    mask = 5'b00101;  // spock: rock, scissors
      default: mask = 5'b00000;
    endcase
    shifted = mask >> b;
    return shifted[0];
  endfunction

  // start_armed stays low after reset until start has been seen low, so a
  // start that is already held high when reset releases is not an edge.
  assign start_edge = start && !start_q && start_armed;

  // Score the captured round and work out what the match state becomes if
  // the round counts. Only consumed while in EVAL.
  always_comb begin
    eval_bad    = move_invalid(mode_q, p1_q) || move_invalid(mode_q, p2_q);
    eval_result = RES_TIE;
    if (eval_bad) begin
      eval_result = RES_BAD;
    end else if (p1_q == p2_q) begin
      eval_result = RES_TIE;
    end else if (beats(p1_q, p2_q)) begin
      eval_result = RES_P1;
    end else begin
      eval_result = RES_P2;
    end

    p1_next = p1_score;
    p2_next = p2_score;
    if (eval_result == RES_P1) begin
      p1_next = p1_score + SCORE_W'(1);
    end
    if (eval_result == RES_P2) begin
      p2_next = p2_score + SCORE_W'(1);
    end
    count_next = round_count + ROUND_W'(1);

    // Counters stop here, so they can never pass the target or the limit.
    match_end = (p1_next == TARGET) || (p2_next == TARGET) ||
                (count_next == LIMIT);

    winner_next = WIN_DRAW;
    if (p1_next == TARGET) begin
      winner_next = WIN_P1;
    end else if (p2_next == TARGET) begin
      winner_next = WIN_P2;
    end else if (p1_next > p2_next) begin
      winner_next = WIN_P1;
    end else if (p2_next > p1_next) begin
      winner_next = WIN_P2;
    end
  end

  // Match FSM with registered outputs. clear_match overrides every state
  // and swallows a coincident start edge; start_q keeps tracking start in
  // all states so an edge arriving during EVAL/DONE is consumed, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      start_armed  <= 1'b0;
      mode_q       <= 1'b0;
      p1_q         <= 3'd0;
      p2_q         <= 3'd0;
      round_valid  <= 1'b0;
      round_result <= RES_TIE;
      p1_score     <= '0;
      p2_score     <= '0;
      round_count  <= '0;
      match_over   <= 1'b0;
      match_winner <= WIN_NONE;
    end else begin
      start_q     <= start;
      round_valid <= 1'b0;
      if (!start) begin
        start_armed <= 1'b1;
      end

      if (clear_match) begin
        state        <= IDLE;
        p1_score     <= '0;
        p2_score     <= '0;
        round_count  <= '0;
        match_over   <= 1'b0;
        match_winner <= WIN_NONE;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              mode_q <= mode;
              p1_q   <= p1_move;
              p2_q   <= p2_move;
              state  <= EVAL;
            end
          end

          EVAL: begin
            round_valid  <= 1'b1;
            round_result <= eval_result;
            state        <= IDLE;
            if (!eval_bad) begin
              p1_score    <= p1_next;
              p2_score    <= p2_next;
              round_count <= count_next;
              if (match_end) begin
                state        <= DONE;
                match_over   <= 1'b1;
                match_winner <= winner_next;
              end
            end
          end

          DONE: begin
            state <= DONE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match.sv
// ---------------------------------------------------------------------------
// tb_rps_match
//
// Self-checking bench for rps_match. A table of single-round vectors, a few
// hand-written match sequences (win by target, seven ties, clear in DONE,
// reset mid-round) and a randomized run are all compared against a
// behavioural match model kept in this file.
// ---------------------------------------------------------------------------
module tb_rps_match;

  localparam int WT = 3;
  localparam int SW = 4;
  localparam int MR = 7;
  localparam int RW = $clog2(MR + 1);

  // Cyclic ordering rock, spock, paper, lizard, scissors: a move beats the
  // two moves one and two steps behind it. POS maps move codes into it.
  localparam int POS[5] = '{0, 2, 4, 3, 1};

  typedef struct {
    int md;
    int a;
    int b;
    int res;
    int s1;
    int s2;
    int cnt;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          clear_match;
  logic          mode;
  logic [2:0]    p1_move;
  logic [2:0]    p2_move;
  logic          round_valid;
  logic [1:0]    round_result;
  logic [SW-1:0] p1_score;
  logic [SW-1:0] p2_score;
  logic [RW-1:0] round_count;
  logic          match_over;
  logic [1:0]    match_winner;

  int n_checks = 0;
  int n_pass   = 0;

  int m_p1, m_p2, m_rounds, m_over, m_winner, m_last;
  int got_pulses, got_lat, got_result, got_over;

  vec_t vecs[14];

  rps_match #(
    .WIN_TARGET (WT),
    .SCORE_W    (SW),
    .MAX_ROUNDS (MR),
    .ROUND_W    (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear_match  (clear_match),
    .mode         (mode),
    .p1_move      (p1_move),
    .p2_move      (p2_move),
    .round_valid  (round_valid),
    .round_result (round_result),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .round_count  (round_count),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream hangs.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int refResult(input int md, input int a, input int b);
    int lim;
    int d;
    lim = (md != 0) ? 5 : 3;
    if (a >= lim || b >= lim) return 3;
    if (a == b) return 0;
    d = (POS[a] - POS[b] + 5) % 5;
    return (d == 1 || d == 2) ? 1 : 2;
  endfunction

  task automatic modelClear();
    m_p1 = 0; m_p2 = 0; m_rounds = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic modelReset();
    modelClear();
    m_last = 0;
  endtask

  // Raise start with the given moves, then watch four cycles for the pulse.
  // Inputs are scrambled right after the start edge so a round that does
  // not use its captured values shows up.
  task automatic applyStimulus(input logic m, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    mode = m; p1_move = a; p2_move = b; start = 1'b1;
    got_pulses = 0; got_lat = 0; got_result = 0; got_over = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (round_valid) begin
        got_pulses++;
        if (got_lat == 0) begin
          got_lat    = k;
          got_result = round_result;
          got_over   = match_over;
        end
      end
      if (k == 1) begin
        start   = 1'b0;
        mode    = ~m;
        p1_move = 3'($urandom_range(0, 7));
        p2_move = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_result_hold"}, round_result, m_last);
    checkOutput({tag, "_p1_score"}, p1_score, m_p1);
    checkOutput({tag, "_p2_score"}, p2_score, m_p2);
    checkOutput({tag, "_round_count"}, round_count, m_rounds);
    checkOutput({tag, "_match_over"}, match_over, m_over);
    checkOutput({tag, "_match_winner"}, match_winner, m_winner);
  endtask

  task automatic playRound(input int m, input int a, input int b);
    int exp_pulse;
    int r;
    exp_pulse = (m_over == 0) ? 1 : 0;
    r = refResult(m, a, b);
    if (exp_pulse == 1) begin
      m_last = r;
      if (r != 3) begin
        m_rounds++;
        if (r == 1) m_p1++;
        if (r == 2) m_p2++;
        if (m_p1 == WT || m_p2 == WT || m_rounds == MR) begin
          m_over = 1;
          if (m_p1 == WT)      m_winner = 1;
          else if (m_p2 == WT) m_winner = 2;
          else if (m_p1 > m_p2) m_winner = 1;
          else if (m_p2 > m_p1) m_winner = 2;
          else                  m_winner = 3;
        end
      end
    end
    applyStimulus(m[0], a[2:0], b[2:0]);
    checkOutput("pulse_count", got_pulses, exp_pulse);
    if (exp_pulse == 1) begin
      checkOutput("pulse_latency", got_lat, 2);
      checkOutput("result_at_pulse", got_result, r);
      checkOutput("over_with_pulse", got_over, m_over);
    end
    checkState("round");
  endtask

  task automatic clearMatch(input bit with_start);
    @(negedge clk);
    clear_match = 1'b1;
    if (with_start) start = 1'b1;
    got_pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        clear_match = 1'b0;
        start       = 1'b0;
      end
      if (round_valid) got_pulses++;
    end
    modelClear();
    checkOutput("clear_no_pulse", got_pulses, 0);
    checkState("clear");
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_round_valid"}, round_valid, 0);
    checkOutput({tag, "_round_result"}, round_result, 0);
    checkOutput({tag, "_p1_score"}, p1_score, 0);
    checkOutput({tag, "_p2_score"}, p2_score, 0);
    checkOutput({tag, "_round_count"}, round_count, 0);
    checkOutput({tag, "_match_over"}, match_over, 0);
    checkOutput({tag, "_match_winner"}, match_winner, 0);
  endtask

  initial begin
    // md, p1, p2, result, p1_score, p2_score, round_count after one round
    vecs[0]  = '{0, 0, 2, 1, 1, 0, 1};
    vecs[1]  = '{0, 3, 0, 3, 0, 0, 0};
    vecs[2]  = '{1, 3, 0, 2, 0, 1, 1};
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 1};
    vecs[4]  = '{1, 4, 2, 1, 1, 0, 1};
    vecs[5]  = '{1, 2, 4, 2, 0, 1, 1};
    vecs[6]  = '{1, 5, 0, 3, 0, 0, 0};
    vecs[7]  = '{0, 0, 7, 3, 0, 0, 0};
    vecs[8]  = '{1, 3, 4, 1, 1, 0, 1};
    vecs[9]  = '{0, 2, 1, 1, 1, 0, 1};
    vecs[10] = '{1, 1, 4, 1, 1, 0, 1};
    vecs[11] = '{1, 4, 4, 0, 0, 0, 1};
    vecs[12] = '{0, 2, 0, 2, 0, 1, 1};
    vecs[13] = '{1, 3, 1, 1, 1, 0, 1};

    rst = 1'b1; start = 1'b0; clear_match = 1'b0;
    mode = 1'b0; p1_move = 3'd0; p2_move = 3'd0;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Single-round vectors from a cleared match.
    for (int i = 0; i < 14; i++) begin
      clearMatch(1'b0);
      playRound(vecs[i].md, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_result", i), got_result, vecs[i].res);
      checkOutput($sformatf("vec%0d_p1", i), p1_score, vecs[i].s1);
      checkOutput($sformatf("vec%0d_p2", i), p2_score, vecs[i].s2);
      checkOutput($sformatf("vec%0d_count", i), round_count, vecs[i].cnt);
    end

    // P1 wins three straight, then a fourth start is ignored.
    clearMatch(1'b0);
    playRound(0, 0, 2);
    playRound(0, 1, 0);
    playRound(0, 2, 1);
    checkOutput("target_over", match_over, 1);
    checkOutput("target_winner", match_winner, 1);
    playRound(0, 0, 2);
    checkOutput("ignored_pulses", got_pulses, 0);
    checkOutput("ignored_p1", p1_score, 3);

    // clear_match in DONE with a coincident start rise, then a clean round.
    clearMatch(1'b1);
    playRound(0, 1, 0);
    checkOutput("after_clear_count", round_count, 1);
    checkOutput("after_clear_result", got_result, 1);

    // clear_match with a start rise while IDLE must also swallow the start.
    clearMatch(1'b1);

    // Seven tied rounds end in a draw.
    clearMatch(1'b0);
    for (int i = 0; i < 7; i++) playRound(1, i % 5, i % 5);
    checkOutput("ties_winner", match_winner, 3);
    checkOutput("ties_count", round_count, 7);
    checkOutput("ties_over", match_over, 1);

    // Round limit reached with no one at target: higher score wins.
    clearMatch(1'b0);
    playRound(0, 0, 2);
    playRound(0, 0, 2);
    playRound(0, 0, 1);
    for (int i = 0; i < 4; i++) playRound(0, 2, 2);
    checkOutput("limit_winner", match_winner, 1);

    // Reset while in EVAL with start held high through the release.
    clearMatch(1'b0);
    @(negedge clk);
    mode = 1'b0; p1_move = 3'd0; p2_move = 3'd2; start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAllZero("rst_eval");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    got_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (round_valid) got_pulses++;
    end
    checkOutput("rst_eval_no_pulse", got_pulses, 0);
    checkOutput("rst_eval_count", round_count, 0);
    start = 1'b0;
    playRound(0, 0, 2);
    checkOutput("rst_then_round_p1", p1_score, 1);

    // Randomized matches with occasional restarts.
    clearMatch(1'b0);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        clearMatch(1'($urandom_range(0, 1)));
      end else begin
        playRound(int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 5)));
      end
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rps_match.md
RPS_MATCH -- requirements
Module: rps_match

Interface
REQ-001 Parameter WIN_TARGET, default 3: round wins needed to take the match; legal range 1..(2^SCORE_W)-1.
REQ-002 Parameter SCORE_W, default 4: width of each score counter.
REQ-003 Parameter MAX_ROUNDS, default 7: round limit for one match, ties included; ROUND_W = $clog2(MAX_ROUNDS+1).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  level input; only its rising edge requests a round.
REQ-007 clear_match  in  1  synchronous match restart, active high.
REQ-008 mode  in  1  0 = classic (3 moves), 1 = extended (5 moves).
REQ-009 p1_move  in  3  player-1 move: 0 rock, 1 paper, 2 scissors, 3 lizard, 4 spock.
REQ-010 p2_move  in  3  player-2 move, same encoding.
REQ-011 round_valid  out  1  one-cycle pulse; round_result is valid while it is high.
REQ-012 round_result  out  2  00 tie, 01 P1 wins, 10 P2 wins, 11 invalid move.
REQ-013 p1_score, p2_score  out  SCORE_W  round-win counts.
REQ-014 round_count  out  ROUND_W  number of scored rounds (ties included, invalid excluded).
REQ-015 match_over  out  1  high while in DONE.
REQ-016 match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-017 The FSM SHALL have states IDLE, EVAL and DONE, all registered.
REQ-018 A start edge is start=1 while registered start_q=0 at a clock edge. start_q SHALL update every cycle in every state.
REQ-019 In IDLE, a start edge SHALL capture mode, p1_move and p2_move into registers and move the FSM to EVAL.
REQ-020 Start edges in EVAL or DONE SHALL be ignored, not queued.
REQ-021 The EVAL state SHALL last exactly one cycle. On leaving EVAL, round_valid=1 and round_result SHALL be registered, so round_valid is high in the cycle after EVAL: a latency of 2 clocks from the sampling edge.
REQ-022 A move is invalid if it is >=3 in classic mode or >=5 in extended mode.
REQ-023 If either move is invalid, the result SHALL be 11 and scores and round_count SHALL NOT change.
REQ-024 Win table: rock beats scissors and lizard; paper beats rock and spock; scissors beats paper and lizard; lizard beats paper and spock; spock beats rock and scissors; equal moves tie.
REQ-025 A valid round SHALL increment round_count. A win SHALL also increment the winner's score. A tie SHALL change no score.
REQ-026 After a valid round, the FSM goes to DONE if a score equals WIN_TARGET or round_count equals MAX_ROUNDS; otherwise it returns to IDLE.
REQ-027 On entry to DONE, match_winner SHALL be:
  - the player at WIN_TARGET, if any;
  - else the higher score;
  - else 11 (draw).
  match_over SHALL rise in the same cycle as round_valid.
REQ-028 Scores cannot exceed WIN_TARGET and round_count cannot exceed MAX_ROUNDS; no wrap-around is possible.
REQ-029 clear_match SHALL take effect in any state: scores, round_count, match_winner and match_over go to 0, round_valid is forced to 0, and the FSM goes to IDLE.
REQ-030 If clear_match and a start edge occur together, clear_match SHALL win and the start edge SHALL be discarded.
REQ-031 round_result SHALL hold its last value between pulses.
REQ-032 Mode changes between rounds SHALL be allowed; each round uses the mode captured with it.

Reset
REQ-033 While rst=1, all of the following SHALL be 0 immediately, independent of clk: outputs, start_q, captured move and mode registers. The FSM SHALL be in IDLE.
REQ-034 Asserting rst mid-round (in EVAL) SHALL abort the round with no round_valid pulse.
REQ-035 After rst deasserts, a start already held high SHALL NOT count as an edge until it has been seen low.

Verification (defaults: WIN_TARGET=3, MAX_ROUNDS=7)
REQ-036 Classic mode, P1 rock vs P2 scissors, start pulsed -> 2 clocks later round_valid=1 for one cycle, result 01, p1_score=1, round_count=1.
REQ-037 P1 wins three rounds in a row -> on the third pulse match_over=1 and match_winner=01. A fourth start is ignored: no pulse, scores unchanged.
REQ-038 Classic mode, P1 lizard (3) vs P2 rock -> result 11, scores 0, round_count 0. The same moves in extended mode -> result 10.
REQ-039 Seven tied rounds -> match_over=1, match_winner=11, round_count=7, both scores 0.
REQ-040 clear_match asserted in DONE together with a start rise -> scores and count 0, IDLE, no round_valid. The next clean start edge plays normally.
REQ-041 rst asserted during EVAL with start held high, then released -> outputs 0 and no round_valid. A round begins only after start goes low then high.
